// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory slave.
// One outstanding transaction at a time; a stalled slave gets an error completion
// after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  // requester 0
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_error,
  output logic        m0_ready,
  // requester 1
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_error,
  output logic        m1_ready,
  // shared slave side
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_error,
  input  logic        s_ready
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            instr_q, instr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;

  logic            win;
  logic            rsp_ready;
  logic            rsp_error;
  logic [DW-1:0]   rsp_rdata;

  // Winner: the lone valid requester, or the pointer's choice on contention
  assign win = (m0_valid && m1_valid) ? ptr_q : m1_valid;

  // State, grant, pointer, timeout counter and captured request
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Next-state logic and the completion response for the granted requester
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rsp_ready = 1'b0;
    rsp_error = 1'b0;
    rsp_rdata = '0;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          grant_d = win;
          cnt_d   = '0;
          if (win) begin
            instr_d = m1_instr;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            wstrb_d = m1_wstrb;
          end else begin
            instr_d = m0_instr;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
            wstrb_d = m0_wstrb;
          end
        end
      end
      BUSY: begin
        if (s_ready) begin
          // slave response wins even on the timeout cycle
          rsp_ready = 1'b1;
          rsp_error = s_error;
          rsp_rdata = s_rdata;
          state_d   = IDLE;
          ptr_d     = ~grant_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_ready = 1'b1;
          rsp_error = 1'b1;
          state_d   = IDLE;
          ptr_d     = ~grant_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Slave-side outputs are forced quiet while reset is held
  assign s_valid = reset && (state_q == BUSY);
  assign s_instr = reset && instr_q;
  assign s_addr  = reset ? addr_q  : '0;
  assign s_wdata = reset ? wdata_q : '0;
  assign s_wstrb = reset ? wstrb_q : '0;

  // Completion is steered only to the granted requester
  assign m0_ready = reset && rsp_ready && !grant_q;
  assign m0_error = reset && rsp_error && !grant_q;
  assign m0_rdata = (reset && rsp_ready && !grant_q) ? rsp_rdata : '0;
  assign m1_ready = reset && rsp_ready && grant_q;
  assign m1_error = reset && rsp_error && grant_q;
  assign m1_rdata = (reset && rsp_ready && grant_q) ? rsp_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, contention, timeout, timeout tie,
// slave error and reset while busy.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_valid, m0_instr;
  logic [31:0] m0_addr, m0_wdata;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_rdata;
  logic        m0_error, m0_ready;
  logic        m1_valid, m1_instr;
  logic [31:0] m1_addr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_rdata;
  logic        m1_error, m1_ready;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_error, s_ready;

  int n_checks;
  int n_fail;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .m0_valid (m0_valid),
    .m0_instr (m0_instr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_rdata (m0_rdata),
    .m0_error (m0_error),
    .m0_ready (m0_ready),
    .m1_valid (m1_valid),
    .m1_instr (m1_instr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_rdata (m1_rdata),
    .m1_error (m1_error),
    .m1_ready (m1_ready),
    .s_valid  (s_valid),
    .s_instr  (s_instr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_error  (s_error),
    .s_ready  (s_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_rdata  = '0;   s_error  = 1'b0; s_ready = 1'b0;

    // reset: all outputs quiet even with slave strobes asserted
    tick(); tick();
    s_ready = 1'b1; s_error = 1'b1; s_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_s_valid",  32'(s_valid),  32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_error", 32'(m1_error), 32'd0);
    check("rst_m0_rdata", m0_rdata,      32'd0);
    check("rst_s_addr",   s_addr,        32'd0);
    tick();
    reset = 1'b1; s_ready = 1'b0; s_error = 1'b0; s_rdata = '0;

    // single read from m0
    m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wstrb = 4'h0;
    #1;
    check("rd_idle_s_valid", 32'(s_valid),  32'd0);
    check("rd_idle_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check("rd_s_valid",  32'(s_valid),  32'd1);
    check("rd_s_addr",   s_addr,        32'h0000_1000);
    check("rd_s_wstrb",  32'(s_wstrb),  32'd0);
    check("rd_m0_ready", 32'(m0_ready), 32'd1);
    check("rd_m0_rdata", m0_rdata,      32'hDEAD_BEEF);
    check("rd_m0_error", 32'(m0_error), 32'd0);
    check("rd_m1_ready", 32'(m1_ready), 32'd0);
    check("rd_m1_rdata", m1_rdata,      32'd0);
    tick();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    #1;
    check("rd_done_s_valid",  32'(s_valid),  32'd0);
    check("rd_done_m0_ready", 32'(m0_ready), 32'd0);

    // contention right after reset: m0, m1, m0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h0000_00A0; m0_wdata = 32'hA0A0_A0A0; m0_wstrb = 4'hF;
    m1_valid = 1'b1; m1_addr = 32'h0000_00B0; m1_wdata = 32'hB0B0_B0B0; m1_wstrb = 4'h5;
    #1;
    check("ct_idle_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    check("ct_g0_s_addr",   s_addr,        32'h0000_00A0);
    check("ct_g0_s_wdata",  s_wdata,       32'hA0A0_A0A0);
    check("ct_g0_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    s_ready = 1'b1; s_rdata = 32'h0000_0011;
    #1;
    check("ct_g0_done_m0_ready", 32'(m0_ready), 32'd1);
    check("ct_g0_done_m0_rdata", m0_rdata,      32'h0000_0011);
    check("ct_g0_done_m1_ready", 32'(m1_ready), 32'd0);
    check("ct_g0_done_m1_rdata", m1_rdata,      32'd0);
    tick();
    s_ready = 1'b0; s_rdata = '0;
    #1;
    check("ct_gap_s_valid",  32'(s_valid),  32'd0);
    check("ct_gap_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    check("ct_g1_s_addr",  s_addr,       32'h0000_00B0);
    check("ct_g1_s_wstrb", 32'(s_wstrb), 32'h5);
    s_ready = 1'b1; s_rdata = 32'h0000_0022;
    #1;
    check("ct_g1_m1_ready", 32'(m1_ready), 32'd1);
    check("ct_g1_m1_rdata", m1_rdata,      32'h0000_0022);
    check("ct_g1_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    s_ready = 1'b0;
    tick();
    check("ct_g2_s_addr", s_addr, 32'h0000_00A0);
    s_ready = 1'b1; s_rdata = 32'h0000_0033;
    #1;
    check("ct_g2_m0_ready", 32'(m0_ready), 32'd1);
    check("ct_g2_m1_ready", 32'(m1_ready), 32'd0);
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();

    // timeout: m1 write, slave silent, error on the 8th busy cycle
    m1_valid = 1'b1; m1_addr = 32'h0000_00C0; m1_wdata = 32'h0000_55AA; m1_wstrb = 4'h3;
    s_rdata = 32'h1234_5678;
    tick();
    check("to_s_wdata", s_wdata, 32'h0000_55AA);
    for (int k = 1; k < 8; k++) begin
      check($sformatf("to_early_m1_ready_%0d", k), 32'(m1_ready), 32'd0);
      tick();
    end
    check("to_m1_ready", 32'(m1_ready), 32'd1);
    check("to_m1_error", 32'(m1_error), 32'd1);
    check("to_m1_rdata", m1_rdata,      32'd0);
    check("to_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    m1_valid = 1'b0;
    #1;
    check("to_after_s_valid",  32'(s_valid),  32'd0);
    check("to_after_m1_ready", 32'(m1_ready), 32'd0);

    // timeout tie: slave ready on the 8th busy cycle wins
    m1_addr = 32'h0000_00D0; m1_wstrb = 4'h0; m1_valid = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ready = 1'b1; s_error = 1'b0; s_rdata = 32'hCAFE_F00D;
    #1;
    check("tie_m1_ready", 32'(m1_ready), 32'd1);
    check("tie_m1_error", 32'(m1_error), 32'd0);
    check("tie_m1_rdata", m1_rdata,      32'hCAFE_F00D);
    tick();
    m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();

    // slave error on an m0 fetch; m0 drops valid mid-transaction
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_00E0; m0_wstrb = 4'h0;
    tick();
    check("err_s_instr", 32'(s_instr), 32'd1);
    m0_valid = 1'b0;
    s_ready = 1'b1; s_error = 1'b1; s_rdata = 32'h0000_0BAD;
    #1;
    check("err_m0_ready", 32'(m0_ready), 32'd1);
    check("err_m0_error", 32'(m0_error), 32'd1);
    check("err_m1_error", 32'(m1_error), 32'd0);
    tick();
    m0_instr = 1'b0; s_ready = 1'b0; s_error = 1'b0; s_rdata = '0;

    // slave strobes in IDLE are ignored
    s_ready = 1'b1; s_error = 1'b1; s_rdata = 32'h0000_0099;
    #1;
    check("idle_m0_ready", 32'(m0_ready), 32'd0);
    check("idle_m1_error", 32'(m1_error), 32'd0);
    tick();
    s_ready = 1'b0; s_error = 1'b0; s_rdata = '0;
    #1;
    check("idle_s_valid", 32'(s_valid), 32'd0);

    // reset during BUSY drops the transaction; pending m1 then served
    m0_valid = 1'b1; m0_addr = 32'h0000_00F0;
    tick();
    check("rb_busy_s_valid", 32'(s_valid), 32'd1);
    reset = 1'b0; s_ready = 1'b1; s_rdata = 32'h0000_0066;
    m1_valid = 1'b1; m1_addr = 32'h0000_01F0; m1_wstrb = 4'h0;
    #1;
    check("rb_rst_s_valid",  32'(s_valid),  32'd0);
    check("rb_rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rb_rst_m0_rdata", m0_rdata,      32'd0);
    tick();
    reset = 1'b1; m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    #1;
    check("rb_idle_s_valid",  32'(s_valid),  32'd0);
    check("rb_idle_s_addr",   s_addr,        32'd0);
    check("rb_idle_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    check("rb_m1_s_valid", 32'(s_valid), 32'd1);
    check("rb_m1_s_addr",  s_addr,       32'h0000_01F0);
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    #1;
    check("rb_m1_ready", 32'(m1_ready), 32'd1);
    check("rb_m1_rdata", m1_rdata,      32'h0000_0077);
    check("rb_m0_ready", 32'(m0_ready), 32'd0);
    tick();
    m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
